lsb: RTL and testbench
======================

LSB -- requirements
Module: lsb

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 rdy  input  1  when low, hold all state; outputs keep their values.
REQ-004 clear  input  1  mispredict flush pulse from ROB.
REQ-005 issue_ok  input  1  decoder pushes one memory op this cycle.
REQ-006 issue_op  input  6  op[5:3]=101 load, 111 store; op[2:0]=funct3: B=000, H=001, W=010, BU=100, HU=101.
REQ-007 issue_Vj, issue_Vk  input  32  base, store data values.
REQ-008 issue_Qj, issue_Qk  input  4  ROB tags of the pending operands.
REQ-009 issue_Qj_ok, issue_Qk_ok  input  1  operand value valid at issue.
REQ-010 issue_imm  input  32  sign-extended offset.
REQ-011 issue_rob  input  4  ROB tag of this op.
REQ-012 is_lsb_full  output  1  issue blocked.
REQ-013 commit_ok, commit_pos  input  1/4  ROB commits the store with that tag.
REQ-014 cdb1_ok/en/val, cdb2_ok/en/val  input  1/4/32  two result broadcasts.
REQ-015 mem_req, mem_wr  output  1  request held; 1=write.
REQ-016 mem_addr, mem_wdata  output  32; mem_size  output  2 (0=byte, 1=half, 2=word).
REQ-017 mem_done, mem_rdata  input  1/32  one-cycle completion; rdata valid with done.
REQ-018 out_ok, out_en, out_val  output  1/4/32  result broadcast to ROB and stations.

Function
REQ-019 Buffer: 8-entry circular FIFO, 3-bit head/tail pointers, 4-bit count; wrap 7->0.
REQ-020 Entry fields: op, Vj, Vk, Qj, Qk, rj, rk (ready), imm, rob, committed, reported.
REQ-021 is_lsb_full = (count >= 7), combinational.
REQ-022 On issue_ok, write entry at tail, tail+1, count+1; an issue with is_lsb_full high is a protocol error.
REQ-023 Any cdbN_ok with en equal to a not-ready Qj/Qk sets that value and ready bit; the same wakeup applies to the issuing entry's operands in the same cycle.
REQ-024 On commit_ok, the valid store entry whose rob equals commit_pos sets committed.
REQ-025 Address = Vj + imm, 32-bit wrap.
REQ-026 FSM states IDLE, BUSY. From IDLE, when count>0 and head entry has rj (load) or rj&rk&committed (store): drive the request, go to BUSY.
REQ-027 In BUSY, hold mem_req=1 and the request outputs unchanged until mem_done; then mem_req<=0, pop head (head+1, count-1), return to IDLE; at most one request is in flight.
REQ-028 Store wdata = Vk; size from funct3[1:0].
REQ-029 Load completion: out_ok=1 one cycle, out_en=rob, out_val = rdata sign- (000/001) or zero- (100/101) extended from bit 7/15; word unchanged.
REQ-030 Store announce: when no load result is emitted in a cycle, the oldest entry that is a store with rj&rk and not reported drives out_ok=1, out_en=rob, out_val=0, and sets reported; load result has priority.
REQ-031 out_ok defaults to 0 every cycle it is not driven.
REQ-032 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-033 Clear: drop every entry without committed (committed stores form a prefix from head); tail <= head + number committed; count adjusted; out_ok <= 0.
REQ-034 Clear while a load is BUSY: the transaction completes, its pop occurs, and no out_ok is raised; a committed store in BUSY completes normally.

Reset
REQ-035 On rst: head=tail=0, count=0, state IDLE, all committed/reported cleared, mem_req=0, mem_wr=0, out_ok=0, mem_addr=mem_wdata=out_val=0, mem_size=0, out_en=0.
REQ-036 rst has priority over clear and rdy; rst mid-transaction abandons the request.

Verification
REQ-037 Ready LW issued, tag 3, addr 0x100, mem returns 0x8000_00FF after 2 cycles -> one request; out_ok pulse, out_en=3, out_val=0x8000_00FF; count 0.
REQ-038 LB on rdata 0x80, then LBU on 0x80 -> out_val 0xFFFF_FF80, then 0x0000_0080.
REQ-039 SW tag 5, Vk pending on tag 2; cdb1 tag 2 val 0xDEAD -> store announce out_en=5; no mem_req until commit_pos=5; then write 0xDEAD, size 2.
REQ-040 Issue 7 ops -> is_lsb_full=1; one pop -> is_lsb_full=0; pointers wrap 7->0 without loss.
REQ-041 One committed store plus two uncommitted loads, clear -> count=1, store still written, no out_ok for the loads.

Source files
------------

// File: rtl/lsb.sv
// Load/store buffer: 8-entry in-order queue that wakes operands from two CDBs,
// issues one memory transaction at a time and broadcasts load results and store readiness.
module lsb (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rdy,
    input  logic        i_clear,
    input  logic        i_issue_ok,
    input  logic [5:0]  i_issue_op,
    input  logic [31:0] i_issue_vj,
    input  logic [31:0] i_issue_vk,
    input  logic [3:0]  i_issue_qj,
    input  logic [3:0]  i_issue_qk,
    input  logic        i_issue_qj_ok,
    input  logic        i_issue_qk_ok,
    input  logic [31:0] i_issue_imm,
    input  logic [3:0]  i_issue_rob,
    output logic        o_is_lsb_full,
    input  logic        i_commit_ok,
    input  logic [3:0]  i_commit_pos,
    input  logic        i_cdb1_ok,
    input  logic [3:0]  i_cdb1_en,
    input  logic [31:0] i_cdb1_val,
    input  logic        i_cdb2_ok,
    input  logic [3:0]  i_cdb2_en,
    input  logic [31:0] i_cdb2_val,
    output logic        o_mem_req,
    output logic        o_mem_wr,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [1:0]  o_mem_size,
    input  logic        i_mem_done,
    input  logic [31:0] i_mem_rdata,
    output logic        o_out_ok,
    output logic [3:0]  o_out_en,
    output logic [31:0] o_out_val
);

    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_STORE = 3'b111;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    logic [5:0]  r_op  [8];
    logic [31:0] r_vj  [8];
    logic [31:0] r_vk  [8];
    logic [3:0]  r_qj  [8];
    logic [3:0]  r_qk  [8];
    logic [31:0] r_imm [8];
    logic [3:0]  r_rob [8];
    logic [7:0]  r_rj;
    logic [7:0]  r_rk;
    logic [7:0]  r_com;
    logic [7:0]  r_rep;

    logic [2:0]  r_head;
    logic [2:0]  r_tail;
    logic [3:0]  r_count;
    state_t      r_state;
    logic        r_drop;

    logic        r_mem_req;
    logic        r_mem_wr;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [1:0]  r_mem_size;
    logic        r_out_ok;
    logic [3:0]  r_out_en;
    logic [31:0] r_out_val;

    logic [7:0]  w_valid;
    logic        w_ann_hit;
    logic [2:0]  w_ann_idx;
    logic [3:0]  w_keep;
    logic        w_keep_run;
    logic [2:0]  w_idx;
    logic [2:0]  w_off;
    logic        w_head_load;
    logic        w_head_store;
    logic        w_launch;
    logic        w_push;
    logic        w_pop;
    logic        w_iss_rj;
    logic        w_iss_rk;
    logic [31:0] w_iss_vj;
    logic [31:0] w_iss_vk;
    logic [31:0] w_ld_val;

    assign o_is_lsb_full = (r_count >= 4'd7);
    assign o_mem_req     = r_mem_req;
    assign o_mem_wr      = r_mem_wr;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_mem_size    = r_mem_size;
    assign o_out_ok      = r_out_ok;
    assign o_out_en      = r_out_en;
    assign o_out_val     = r_out_val;

    assign w_head_load  = (r_op[r_head][5:3] == OP_LOAD);
    assign w_head_store = (r_op[r_head][5:3] == OP_STORE);
    assign w_launch     = (r_count != 4'd0) &&
                          ((w_head_load && r_rj[r_head]) ||
                           (w_head_store && r_rj[r_head] && r_rk[r_head] && r_com[r_head]));
    assign w_push       = i_issue_ok && !i_clear;
    assign w_pop        = (r_state == S_BUSY) && i_mem_done;

    always_comb begin
        w_valid    = '0;
        w_ann_hit  = 1'b0;
        w_ann_idx  = '0;
        w_keep     = '0;
        w_keep_run = 1'b1;
        w_idx      = '0;
        w_off      = '0;
        for (int i = 0; i < 8; i++) begin
            w_off      = 3'(i) - r_head;
            w_valid[i] = ({1'b0, w_off} < r_count);
        end
        // Descending scan so the entry nearest head wins.
        for (int k = 7; k >= 0; k--) begin
            w_idx = r_head + 3'(k);
            if ((4'(k) < r_count) && (r_op[w_idx][5:3] == OP_STORE) &&
                r_rj[w_idx] && r_rk[w_idx] && !r_rep[w_idx]) begin
                w_ann_hit = 1'b1;
                w_ann_idx = w_idx;
            end
        end
        // Entries surviving a flush: committed prefix, plus an in-flight head.
        for (int k = 0; k < 8; k++) begin
            w_idx = r_head + 3'(k);
            if (w_keep_run && (4'(k) < r_count) &&
                (r_com[w_idx] || ((k == 0) && (r_state == S_BUSY)))) begin
                w_keep = w_keep + 4'd1;
            end else begin
                w_keep_run = 1'b0;
            end
        end
    end

    always_comb begin
        w_iss_rj = i_issue_qj_ok;
        w_iss_vj = i_issue_vj;
        if (!i_issue_qj_ok) begin
            if (i_cdb1_ok && (i_cdb1_en == i_issue_qj)) begin
                w_iss_rj = 1'b1;
                w_iss_vj = i_cdb1_val;
            end else if (i_cdb2_ok && (i_cdb2_en == i_issue_qj)) begin
                w_iss_rj = 1'b1;
                w_iss_vj = i_cdb2_val;
            end
        end
        w_iss_rk = i_issue_qk_ok;
        w_iss_vk = i_issue_vk;
        if (!i_issue_qk_ok) begin
            if (i_cdb1_ok && (i_cdb1_en == i_issue_qk)) begin
                w_iss_rk = 1'b1;
                w_iss_vk = i_cdb1_val;
            end else if (i_cdb2_ok && (i_cdb2_en == i_issue_qk)) begin
                w_iss_rk = 1'b1;
                w_iss_vk = i_cdb2_val;
            end
        end
    end

    always_comb begin
        case (r_op[r_head][2:0])
            3'b000:  w_ld_val = {{24{i_mem_rdata[7]}}, i_mem_rdata[7:0]};
            3'b001:  w_ld_val = {{16{i_mem_rdata[15]}}, i_mem_rdata[15:0]};
            3'b100:  w_ld_val = {24'd0, i_mem_rdata[7:0]};
            3'b101:  w_ld_val = {16'd0, i_mem_rdata[15:0]};
            default: w_ld_val = i_mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_state     <= S_IDLE;
            r_drop      <= 1'b0;
            r_com       <= '0;
            r_rep       <= '0;
            r_rj        <= '0;
            r_rk        <= '0;
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_size  <= '0;
            r_out_ok    <= 1'b0;
            r_out_en    <= '0;
            r_out_val   <= '0;
        end else if (i_rdy) begin
            for (int i = 0; i < 8; i++) begin
                if (w_valid[i] && !r_rj[i]) begin
                    if (i_cdb1_ok && (i_cdb1_en == r_qj[i])) begin
                        r_vj[i] <= i_cdb1_val;
                        r_rj[i] <= 1'b1;
                    end else if (i_cdb2_ok && (i_cdb2_en == r_qj[i])) begin
                        r_vj[i] <= i_cdb2_val;
                        r_rj[i] <= 1'b1;
                    end
                end
                if (w_valid[i] && !r_rk[i]) begin
                    if (i_cdb1_ok && (i_cdb1_en == r_qk[i])) begin
                        r_vk[i] <= i_cdb1_val;
                        r_rk[i] <= 1'b1;
                    end else if (i_cdb2_ok && (i_cdb2_en == r_qk[i])) begin
                        r_vk[i] <= i_cdb2_val;
                        r_rk[i] <= 1'b1;
                    end
                end
                if (i_commit_ok && w_valid[i] && (r_op[i][5:3] == OP_STORE) &&
                    (r_rob[i] == i_commit_pos)) begin
                    r_com[i] <= 1'b1;
                end
            end

            if (w_push) begin
                r_op[r_tail]  <= i_issue_op;
                r_vj[r_tail]  <= w_iss_vj;
                r_vk[r_tail]  <= w_iss_vk;
                r_qj[r_tail]  <= i_issue_qj;
                r_qk[r_tail]  <= i_issue_qk;
                r_rj[r_tail]  <= w_iss_rj;
                r_rk[r_tail]  <= w_iss_rk;
                r_imm[r_tail] <= i_issue_imm;
                r_rob[r_tail] <= i_issue_rob;
                r_com[r_tail] <= 1'b0;
                r_rep[r_tail] <= 1'b0;
            end

            if (i_clear) begin
                r_head  <= r_head + 3'(w_pop);
                r_tail  <= r_head + w_keep[2:0];
                r_count <= w_keep - 4'(w_pop);
            end else begin
                r_head  <= r_head + 3'(w_pop);
                r_tail  <= r_tail + 3'(w_push);
                r_count <= r_count + 4'(w_push) - 4'(w_pop);
            end

            case (r_state)
                S_IDLE: begin
                    if (!i_clear && w_launch) begin
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= w_head_store;
                        r_mem_addr  <= r_vj[r_head] + r_imm[r_head];
                        r_mem_wdata <= r_vk[r_head];
                        r_mem_size  <= r_op[r_head][1:0];
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_pop) begin
                        r_mem_req <= 1'b0;
                        r_drop    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (i_clear && w_head_load) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A load result pre-empts a store announcement in the same cycle.
            if (i_clear) begin
                r_out_ok <= 1'b0;
            end else if (w_pop && w_head_load && !r_drop) begin
                r_out_ok  <= 1'b1;
                r_out_en  <= r_rob[r_head];
                r_out_val <= w_ld_val;
            end else if (w_ann_hit) begin
                r_out_ok         <= 1'b1;
                r_out_en         <= r_rob[w_ann_idx];
                r_out_val        <= '0;
                r_rep[w_ann_idx] <= 1'b1;
            end else begin
                r_out_ok <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsb.sv
// Directed bench for lsb: load-extension vector table plus hand sequences for
// store wakeup/commit, full/wrap, flush and stall behaviour.
module tb_lsb;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rdy;
    logic        i_clear;
    logic        i_issue_ok;
    logic [5:0]  i_issue_op;
    logic [31:0] i_issue_vj, i_issue_vk, i_issue_imm;
    logic [3:0]  i_issue_qj, i_issue_qk, i_issue_rob;
    logic        i_issue_qj_ok, i_issue_qk_ok;
    logic        o_is_lsb_full;
    logic        i_commit_ok;
    logic [3:0]  i_commit_pos;
    logic        i_cdb1_ok, i_cdb2_ok;
    logic [3:0]  i_cdb1_en, i_cdb2_en;
    logic [31:0] i_cdb1_val, i_cdb2_val;
    logic        o_mem_req, o_mem_wr;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [1:0]  o_mem_size;
    logic        i_mem_done;
    logic [31:0] i_mem_rdata;
    logic        o_out_ok;
    logic [3:0]  o_out_en;
    logic [31:0] o_out_val;

    lsb dut (
        .clk(clk), .rst(rst), .i_rdy(i_rdy), .i_clear(i_clear),
        .i_issue_ok(i_issue_ok), .i_issue_op(i_issue_op),
        .i_issue_vj(i_issue_vj), .i_issue_vk(i_issue_vk),
        .i_issue_qj(i_issue_qj), .i_issue_qk(i_issue_qk),
        .i_issue_qj_ok(i_issue_qj_ok), .i_issue_qk_ok(i_issue_qk_ok),
        .i_issue_imm(i_issue_imm), .i_issue_rob(i_issue_rob),
        .o_is_lsb_full(o_is_lsb_full),
        .i_commit_ok(i_commit_ok), .i_commit_pos(i_commit_pos),
        .i_cdb1_ok(i_cdb1_ok), .i_cdb1_en(i_cdb1_en), .i_cdb1_val(i_cdb1_val),
        .i_cdb2_ok(i_cdb2_ok), .i_cdb2_en(i_cdb2_en), .i_cdb2_val(i_cdb2_val),
        .o_mem_req(o_mem_req), .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size),
        .i_mem_done(i_mem_done), .i_mem_rdata(i_mem_rdata),
        .o_out_ok(o_out_ok), .o_out_en(o_out_en), .o_out_val(o_out_val)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // memory responder state
    int          mem_lat = 2;
    logic [31:0] mem_rdata_cfg = 32'h0;
    int          n_req = 0;
    int          hold_bad = 0;
    logic        rec_wr;
    logic [31:0] rec_addr, rec_wdata;
    logic [1:0]  rec_size;
    logic [63:0] wq[$];
    logic [35:0] outq[$];

    initial begin : responder
        bit pend;
        int cnt;
        pend = 0;
        cnt = 0;
        i_mem_done = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            i_mem_done = 1'b0;
            if (pend) begin
                if (!o_mem_req || o_mem_addr !== rec_addr || o_mem_wr !== rec_wr ||
                    o_mem_wdata !== rec_wdata || o_mem_size !== rec_size)
                    hold_bad++;
                if (cnt <= 1) begin
                    i_mem_done = 1'b1;
                    i_mem_rdata = mem_rdata_cfg;
                    pend = 0;
                end else begin
                    cnt--;
                end
            end else if (o_mem_req === 1'b1) begin
                pend = 1;
                cnt = mem_lat;
                n_req++;
                rec_wr = o_mem_wr;
                rec_addr = o_mem_addr;
                rec_wdata = o_mem_wdata;
                rec_size = o_mem_size;
                if (o_mem_wr) wq.push_back({o_mem_addr, o_mem_wdata});
            end
        end
    end

    initial begin : out_monitor
        forever begin
            @(posedge clk);
            #2;
            if (o_out_ok === 1'b1) outq.push_back({o_out_en, o_out_val});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [3:0] qj, input logic [3:0] qk, input logic qjok,
                         input logic qkok, input logic [31:0] imm, input logic [3:0] rob);
        i_issue_ok = 1'b1; i_issue_op = op; i_issue_vj = vj; i_issue_vk = vk;
        i_issue_qj = qj; i_issue_qk = qk; i_issue_qj_ok = qjok; i_issue_qk_ok = qkok;
        i_issue_imm = imm; i_issue_rob = rob;
        step(1);
        i_issue_ok = 1'b0;
    endtask

    task automatic commit(input logic [3:0] pos);
        i_commit_ok = 1'b1; i_commit_pos = pos;
        step(1);
        i_commit_ok = 1'b0;
    endtask

    task automatic take_out(input string name, input logic [3:0] en, input logic [31:0] val);
        logic [35:0] e;
        int c;
        c = 0;
        while (outq.size() == 0 && c < 40) begin
            step(1);
            c++;
        end
        if (outq.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: no out_ok pulse within %0d cycles", name, c);
        end else begin
            e = outq.pop_front();
            chk({name, ".en"}, {28'd0, e[35:32]}, {28'd0, en});
            chk({name, ".val"}, e[31:0], val);
        end
    endtask

    task automatic wait_writes(input int n, input string name);
        int c;
        c = 0;
        while (wq.size() < n && c < 300) begin
            step(1);
            c++;
        end
        if (wq.size() < n) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: %0d writes seen, %0d expected", name, wq.size(), n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        outq.delete();
        wq.delete();
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t vecs[8];

    initial begin
        int base;
        logic [63:0] w;
        vecs[0] = '{3'b000, 32'h0000_0080, 32'hFFFF_FF80};
        vecs[1] = '{3'b100, 32'h0000_0080, 32'h0000_0080};
        vecs[2] = '{3'b001, 32'h0000_8001, 32'hFFFF_8001};
        vecs[3] = '{3'b101, 32'h0000_8001, 32'h0000_8001};
        vecs[4] = '{3'b000, 32'h1234_567F, 32'h0000_007F};
        vecs[5] = '{3'b001, 32'hABCD_7FFF, 32'h0000_7FFF};
        vecs[6] = '{3'b010, 32'hCAFE_BABE, 32'hCAFE_BABE};
        vecs[7] = '{3'b100, 32'hFFFF_FFFF, 32'h0000_00FF};

        rst = 1'b1; i_rdy = 1'b1; i_clear = 1'b0; i_issue_ok = 1'b0;
        i_issue_op = '0; i_issue_vj = '0; i_issue_vk = '0; i_issue_imm = '0;
        i_issue_qj = '0; i_issue_qk = '0; i_issue_qj_ok = 1'b0; i_issue_qk_ok = 1'b0;
        i_issue_rob = '0; i_commit_ok = 1'b0; i_commit_pos = '0;
        i_cdb1_ok = 1'b0; i_cdb1_en = '0; i_cdb1_val = '0;
        i_cdb2_ok = 1'b0; i_cdb2_en = '0; i_cdb2_val = '0;
        step(1);
        do_reset();

        chk("rst.full", {31'd0, o_is_lsb_full}, 32'd0);
        chk("rst.mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst.out_ok", {31'd0, o_out_ok}, 32'd0);
        chk("rst.mem_addr", o_mem_addr, 32'd0);
        chk("rst.out_val", o_out_val, 32'd0);

        // Ready LW tag 3 at 0x100, two-cycle memory
        mem_lat = 2; mem_rdata_cfg = 32'h8000_00FF;
        base = n_req;
        issue(6'b101_010, 32'h0000_00F0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 32'h10, 4'd3);
        take_out("lw", 4'd3, 32'h8000_00FF);
        step(4);
        chk("lw.nreq", n_req - base, 32'd1);
        chk("lw.addr", rec_addr, 32'h100);
        chk("lw.wr", {31'd0, rec_wr}, 32'd0);
        chk("lw.size", {30'd0, rec_size}, 32'd2);
        chk("lw.single_pulse", outq.size(), 32'd0);

        // Load extension table
        mem_lat = 1;
        for (int i = 0; i < 8; i++) begin
            mem_rdata_cfg = vecs[i].rdata;
            issue({3'b101, vecs[i].f3}, 32'h200 + 32'(4 * i), 32'h0, 4'd0, 4'd0, 1'b1, 1'b1,
                  32'h0, 4'(i + 4));
            take_out($sformatf("ld_vec%0d", i), 4'(i + 4), vecs[i].exp);
            chk($sformatf("ld_vec%0d.size", i), {30'd0, rec_size}, {30'd0, vecs[i].f3[1:0]});
            chk($sformatf("ld_vec%0d.addr", i), rec_addr, 32'h200 + 32'(4 * i));
        end

        // Base wakes up in the issue cycle from cdb2
        mem_rdata_cfg = 32'h5555_AAAA;
        i_cdb2_ok = 1'b1; i_cdb2_en = 4'd9; i_cdb2_val = 32'h400;
        issue(6'b101_010, 32'h0, 32'h0, 4'd9, 4'd0, 1'b0, 1'b1, 32'h8, 4'd12);
        i_cdb2_ok = 1'b0;
        take_out("iss_wake", 4'd12, 32'h5555_AAAA);
        chk("iss_wake.addr", rec_addr, 32'h408);

        // SW tag 5, data pending on tag 2, then commit
        step(2);
        outq.delete();
        base = n_req;
        issue(6'b111_010, 32'h300, 32'h0, 4'd0, 4'd2, 1'b1, 1'b0, 32'h4, 4'd5);
        step(3);
        chk("sw.no_early_ann", outq.size(), 32'd0);
        i_cdb1_ok = 1'b1; i_cdb1_en = 4'd2; i_cdb1_val = 32'h0000_DEAD;
        step(1);
        i_cdb1_ok = 1'b0;
        take_out("sw.ann", 4'd5, 32'h0);
        step(5);
        chk("sw.no_req_before_commit", n_req - base, 32'd0);
        commit(4'd5);
        wait_writes(1, "sw.write");
        step(3);
        chk("sw.nreq", n_req - base, 32'd1);
        chk("sw.wr", {31'd0, rec_wr}, 32'd1);
        chk("sw.addr", rec_addr, 32'h304);
        chk("sw.wdata", rec_wdata, 32'h0000_DEAD);
        chk("sw.size", {30'd0, rec_size}, 32'd2);
        chk("sw.ann_once", outq.size(), 32'd0);

        // Fill to 7, pop one, wrap tail 7->0, drain in order
        do_reset();
        mem_lat = 1;
        for (int t = 0; t < 7; t++) begin
            if (t == 6) chk("full.at6", {31'd0, o_is_lsb_full}, 32'd0);
            issue(6'b111_010, 32'h1000, 32'(t * 17), 4'd0, 4'd0, 1'b1, 1'b1, 32'(4 * t), 4'(t));
        end
        chk("full.at7", {31'd0, o_is_lsb_full}, 32'd1);
        commit(4'd0);
        wait_writes(1, "full.pop");
        step(2);
        chk("full.after_pop", {31'd0, o_is_lsb_full}, 32'd0);
        issue(6'b111_010, 32'h1000, 32'(7 * 17), 4'd0, 4'd0, 1'b1, 1'b1, 32'(28), 4'd7);
        chk("full.wrap_refill", {31'd0, o_is_lsb_full}, 32'd1);
        for (int t = 1; t < 8; t++) commit(4'(t));
        wait_writes(8, "wrap.drain");
        step(3);
        for (int t = 0; t < 8; t++) begin
            if (wq.size() > 0) begin
                w = wq.pop_front();
                chk($sformatf("wrap.addr%0d", t), w[63:32], 32'h1000 + 32'(4 * t));
                chk($sformatf("wrap.wdata%0d", t), w[31:0], 32'(t * 17));
            end
        end
        for (int t = 0; t < 8; t++) begin
            if (outq.size() > 0) begin
                w = {28'd0, outq.pop_front()};
                chk($sformatf("wrap.ann%0d", t), {28'd0, w[35:32]}, 32'(t));
            end
        end
        chk("wrap.empty", {31'd0, o_is_lsb_full}, 32'd0);

        // Committed store in flight plus two uncommitted loads, then clear
        do_reset();
        mem_lat = 6;
        base = n_req;
        issue(6'b111_010, 32'h500, 32'h55, 4'd0, 4'd0, 1'b1, 1'b1, 32'h0, 4'd1);
        issue(6'b101_010, 32'h0, 32'h0, 4'd12, 4'd0, 1'b0, 1'b1, 32'h0, 4'd2);
        issue(6'b101_010, 32'h0, 32'h0, 4'd13, 4'd0, 1'b0, 1'b1, 32'h0, 4'd3);
        take_out("clr.st_ann", 4'd1, 32'h0);
        commit(4'd1);
        step(2);
        i_clear = 1'b1;
        step(1);
        i_clear = 1'b0;
        wait_writes(1, "clr.st_write");
        i_cdb1_ok = 1'b1; i_cdb1_en = 4'd12; i_cdb1_val = 32'h600;
        i_cdb2_ok = 1'b1; i_cdb2_en = 4'd13; i_cdb2_val = 32'h700;
        step(1);
        i_cdb1_ok = 1'b0; i_cdb2_ok = 1'b0;
        step(15);
        chk("clr.nreq", n_req - base, 32'd1);
        if (wq.size() > 0) begin
            w = wq.pop_front();
            chk("clr.st_addr", w[63:32], 32'h500);
            chk("clr.st_wdata", w[31:0], 32'h55);
        end
        chk("clr.no_load_out", outq.size(), 32'd0);
        for (int t = 0; t < 7; t++) begin
            if (t == 6) chk("clr.count_at6", {31'd0, o_is_lsb_full}, 32'd0);
            issue(6'b111_010, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 32'h0, 4'(t + 8));
        end
        chk("clr.count_at7", {31'd0, o_is_lsb_full}, 32'd1);

        // Clear while a load is in flight: completes silently, pointers stay sane
        do_reset();
        mem_lat = 4; mem_rdata_cfg = 32'hBAD0_BAD0;
        base = n_req;
        issue(6'b101_010, 32'h800, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 32'h0, 4'd4);
        step(2);
        i_clear = 1'b1;
        step(1);
        i_clear = 1'b0;
        step(12);
        chk("clrld.nreq", n_req - base, 32'd1);
        chk("clrld.no_out", outq.size(), 32'd0);
        mem_lat = 1; mem_rdata_cfg = 32'h1234_5678;
        issue(6'b101_010, 32'h900, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 32'h0, 4'd6);
        take_out("clrld.next", 4'd6, 32'h1234_5678);
        chk("clrld.next_addr", rec_addr, 32'h900);

        // rdy low: issue is ignored
        step(3);
        base = n_req;
        outq.delete();
        i_rdy = 1'b0;
        issue(6'b101_010, 32'hA00, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 32'h0, 4'd7);
        step(3);
        i_rdy = 1'b1;
        step(6);
        chk("rdy.no_req", n_req - base, 32'd0);
        chk("rdy.no_out", outq.size(), 32'd0);

        chk("mem.hold_stable", hold_bad, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
